// File: rtl/worker_collect_pkg.sv
// Shared register map, STATUS/CTRL bit positions and byte-lane masking for worker_collect.
package worker_collect_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    localparam int STATUS_LEVEL_W   = 11;
    localparam int STATUS_EMPTY_BIT = 16;
    localparam int STATUS_FULL_BIT  = 17;
    localparam int STATUS_OVF_BIT   = 18;

    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_OVF_BIT = 1;

    // Disabled byte lanes are stored as zero rather than kept from old contents.
    function automatic logic [31:0] lane_mask(input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/worker_collect_fifo.sv
// Synchronous word FIFO with registered first-word-fall-through head, level and flags.
module worker_collect_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [31:0]              wdata,
    output logic [31:0]              data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_nx;
    logic [LW-1:0] level_after_pop, level_nx;
    logic          do_push, do_pop;

    always_comb begin
        do_push         = push & ~full;
        do_pop          = pop & ~empty;
        rd_ptr_nx       = do_pop ? rd_ptr + 1'b1 : rd_ptr;
        level_after_pop = do_pop ? level - 1'b1 : level;
        level_nx        = do_push ? level_after_pop + 1'b1 : level_after_pop;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            data   <= '0;
        end else begin
            rd_ptr <= rd_ptr_nx;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            level <= level_nx;
            full  <= (level_nx == FULL_LVL);
            empty <= (level_nx == '0);
            // A word pushed into an otherwise-empty queue is not in mem yet; bypass it.
            if (level_nx == '0)             data <= '0;
            else if (level_after_pop == '0) data <= wdata;
            else                            data <= mem[rd_ptr_nx];
        end
    end

endmodule

// File: rtl/worker_collect.sv
// Avalon-MM result collector: DATA writes feed a FIFO drained on a valid/ready stream.
// Define WORKER_COLLECT_DROP_EN to discard writes while full (sticky overflow) instead of stalling.
module worker_collect
    import worker_collect_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] s_in_address,
    input  logic              s_in_write,
    input  logic [31:0]       s_in_writedata,
    input  logic [3:0]        s_in_byteenable,
    input  logic              s_in_read,
    input  logic              s_in_burstcount,
    input  logic              s_in_debugaccess,
    output logic [31:0]       s_in_readdata,
    output logic              s_in_readdatavalid,
    output logic              s_in_waitrequest,
    output logic [31:0]       st_out_data,
    output logic              st_out_valid,
    input  logic              st_out_ready
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic [1:0]    reg_sel;
    logic          data_wr, ctrl_wr, rd_acc, push, pop, flush, clr_ovf;
    logic          fifo_full, fifo_empty, overflow;
    logic [LW-1:0] fifo_level;
    logic [31:0]   count, status_word, rd_mux;
    logic          unused_ok;

    assign reg_sel = s_in_address[1:0];

    always_comb begin
        data_wr = s_in_write & (reg_sel == REG_DATA);
        ctrl_wr = s_in_write & (reg_sel == REG_CTRL) & s_in_byteenable[0];
        push    = data_wr & ~fifo_full;
        pop     = st_out_ready & ~fifo_empty;
        flush   = ctrl_wr & s_in_writedata[CTRL_FLUSH_BIT];
        clr_ovf = ctrl_wr & s_in_writedata[CTRL_CLR_OVF_BIT];
        // A simultaneous write wins the slave port; the read is dropped.
        rd_acc  = s_in_read & ~s_in_write;

        status_word = '0;
        status_word[STATUS_LEVEL_W-1:0] = STATUS_LEVEL_W'(fifo_level);
        status_word[STATUS_EMPTY_BIT]   = fifo_empty;
        status_word[STATUS_FULL_BIT]    = fifo_full;
        status_word[STATUS_OVF_BIT]     = overflow;

        case (reg_sel)
            REG_STATUS: rd_mux = status_word;
            REG_COUNT:  rd_mux = count;
            default:    rd_mux = '0;
        endcase
    end

`ifdef WORKER_COLLECT_DROP_EN
    assign s_in_waitrequest = 1'b0;
`else
    assign s_in_waitrequest = data_wr & fifo_full;
`endif

    assign st_out_valid = ~fifo_empty;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            s_in_readdatavalid <= 1'b0;
            s_in_readdata      <= '0;
            count              <= '0;
            overflow           <= 1'b0;
        end else begin
            s_in_readdatavalid <= rd_acc;
            s_in_readdata      <= rd_acc ? rd_mux : '0;
            if (push) count <= count + 1'b1;
`ifdef WORKER_COLLECT_DROP_EN
            if (data_wr & fifo_full) overflow <= 1'b1;
            else if (clr_ovf)        overflow <= 1'b0;
`else
            overflow <= 1'b0;
`endif
        end
    end

    worker_collect_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (lane_mask(s_in_writedata, s_in_byteenable)),
        .data  (st_out_data),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign unused_ok = &{1'b0, s_in_burstcount, s_in_debugaccess, s_in_address, clr_ovf};

endmodule

// File: tb/tb_worker_collect.sv
// Bench for worker_collect: queue-based reference model, per-cycle compare, directed literal checks.
module tb_worker_collect;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
`ifdef WORKER_COLLECT_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] s_in_address = '0;
    logic              s_in_write = 1'b0;
    logic [31:0]       s_in_writedata = '0;
    logic [3:0]        s_in_byteenable = '0;
    logic              s_in_read = 1'b0;
    logic              s_in_burstcount = 1'b1;
    logic              s_in_debugaccess = 1'b0;
    logic [31:0]       s_in_readdata;
    logic              s_in_readdatavalid;
    logic              s_in_waitrequest;
    logic [31:0]       st_out_data;
    logic              st_out_valid;
    logic              st_out_ready = 1'b0;

    worker_collect #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_clk            (clk),
        .reset_reset_n      (rst_n),
        .s_in_address       (s_in_address),
        .s_in_write         (s_in_write),
        .s_in_writedata     (s_in_writedata),
        .s_in_byteenable    (s_in_byteenable),
        .s_in_read          (s_in_read),
        .s_in_burstcount    (s_in_burstcount),
        .s_in_debugaccess   (s_in_debugaccess),
        .s_in_readdata      (s_in_readdata),
        .s_in_readdatavalid (s_in_readdatavalid),
        .s_in_waitrequest   (s_in_waitrequest),
        .st_out_data        (st_out_data),
        .st_out_valid       (st_out_valid),
        .st_out_ready       (st_out_ready)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: queue of expected stream words plus register state
    logic [31:0] exp_q[$];
    logic [31:0] exp_count = '0;
    logic        exp_ovf = 1'b0;
    logic        exp_rdv = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] out_log[$];

    function automatic logic [31:0] mask_be(input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = 0;
        for (int i = 0; i < 4; i++)
            if (be[i]) r = r + (d & (32'hFF << (8 * i)));
        return r;
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = exp_q.size();
        if (exp_q.size() == 0)     s = s + 32'h0001_0000;
        if (exp_q.size() == DEPTH) s = s + 32'h0002_0000;
        if (exp_ovf)               s = s + 32'h0004_0000;
        return s;
    endfunction

    always @(posedge clk) begin : model
        bit was_full;
        if (!rst_n) begin
            exp_q.delete();
            exp_count = 0;
            exp_ovf = 0;
            exp_rdv = 0;
            exp_rdata = 0;
        end else begin
            was_full = (exp_q.size() == DEPTH);
            exp_rdv = s_in_read && !s_in_write;
            if (exp_rdv) begin
                case (s_in_address[1:0])
                    2'd1:    exp_rdata = model_status();
                    2'd3:    exp_rdata = exp_count;
                    default: exp_rdata = 0;
                endcase
            end
            if (st_out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (s_in_write) begin
                if (s_in_address[1:0] == 2'd0) begin
                    if (!was_full) begin
                        exp_q.push_back(mask_be(s_in_writedata, s_in_byteenable));
                        exp_count = exp_count + 1;
                    end else if (DROP) begin
                        exp_ovf = 1;
                    end
                end else if (s_in_address[1:0] == 2'd2 && s_in_byteenable[0]) begin
                    if (s_in_writedata[0]) exp_q.delete();
                    if (s_in_writedata[1]) exp_ovf = 0;
                end
            end
        end
    end

    // scoreboard: every cycle, away from the active edge
    always @(negedge clk) begin
        check("st_valid", st_out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check("st_data", st_out_data, exp_q[0]);
        check("waitreq", s_in_waitrequest,
              !DROP && s_in_write && s_in_address[1:0] == 2'd0 && exp_q.size() == DEPTH);
        check("rdvalid", s_in_readdatavalid, exp_rdv);
        if (exp_rdv) check("rddata", s_in_readdata, exp_rdata);
        if (st_out_valid && st_out_ready) out_log.push_back(st_out_data);
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_in_write = 0;
        s_in_read = 0;
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        int waited;
        bit stall;
        logic [1:0] hi;
        hi = 2'($urandom_range(0, 3));
        waited = 0;
        s_in_address = {hi, a};
        s_in_writedata = d;
        s_in_byteenable = be;
        s_in_write = 1;
        do begin
            @(negedge clk);
            stall = s_in_waitrequest;
            tick();
            waited++;
        end while (stall && waited < 100);
        if (stall) begin
            total++;
            bad++;
            $display("FAIL write_timeout: waitrequest still 1 after %0d cycles", waited);
        end
        s_in_write = 0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        s_in_address = {2'b00, a};
        s_in_read = 1;
        tick();
        s_in_read = 0;
        @(negedge clk);
        check("rdv_latency", s_in_readdatavalid, 1);
        d = s_in_readdata;
        tick();
    endtask

    logic [31:0] rd;

    initial begin
        tick();
        tick();
        rst_n = 1;
        @(negedge clk);
        check("reset_valid", st_out_valid, 0);
        check("reset_data", st_out_data, 0);
        check("reset_wait", s_in_waitrequest, 0);
        check("reset_rdv", s_in_readdatavalid, 0);
        tick();
        bus_read(2'd1, rd);
        check("status_reset", rd, 32'h0001_0000);

        // ordered drain after ready rises
        out_log.delete();
        for (int i = 1; i <= 3; i++) bus_write(2'd0, 32'hA5A5_0000 + i, 4'hF);
        bus_read(2'd3, rd);
        check("count3", rd, 3);
        st_out_ready = 1;
        repeat (5) tick();
        st_out_ready = 0;
        check("drain_len", out_log.size(), 3);
        if (out_log.size() == 3) begin
            check("drain0", out_log[0], 32'hA5A5_0001);
            check("drain1", out_log[1], 32'hA5A5_0002);
            check("drain2", out_log[2], 32'hA5A5_0003);
        end

        // byte-lane masking
        bus_write(2'd0, 32'h1234_5678, 4'b0101);
        @(negedge clk);
        check("be_mask", st_out_data, 32'h0034_0078);
        tick();
        st_out_ready = 1;
        repeat (2) tick();
        st_out_ready = 0;

        // full: backpressure or drop
        do_reset();
        for (int i = 0; i < DEPTH; i++) bus_write(2'd0, 32'hB000_0000 + i, 4'hF);
        s_in_address = 0;
        s_in_writedata = 32'hB000_0010;
        s_in_byteenable = 4'hF;
        s_in_write = 1;
`ifdef WORKER_COLLECT_DROP_EN
        @(negedge clk);
        check("drop_nowait", s_in_waitrequest, 0);
        tick();
        s_in_write = 0;
        bus_read(2'd1, rd);
        check("drop_status", rd, 32'h0006_0010);
        bus_read(2'd3, rd);
        check("drop_count", rd, 16);
`else
        repeat (3) begin
            @(negedge clk);
            check("wr_held", s_in_waitrequest, 1);
            tick();
        end
        st_out_ready = 1;
        @(negedge clk);
        check("wr_held_pop", s_in_waitrequest, 1);
        tick();
        st_out_ready = 0;
        @(negedge clk);
        check("wr_release", s_in_waitrequest, 0);
        tick();
        s_in_write = 0;
        bus_read(2'd1, rd);
        check("full_status", rd, 32'h0002_0010);
        bus_read(2'd3, rd);
        check("full_count", rd, 17);
`endif
        st_out_ready = 1;
        repeat (DEPTH + 2) tick();
        st_out_ready = 0;

        // flush racing a pop, then overflow clear
        for (int i = 0; i < 5; i++) bus_write(2'd0, 32'hC000_0000 + i, 4'hF);
        s_in_address = 4'd2;
        s_in_writedata = 32'h1;
        s_in_byteenable = 4'h1;
        s_in_write = 1;
        st_out_ready = 1;
        tick();
        s_in_write = 0;
        st_out_ready = 0;
        @(negedge clk);
        check("flush_valid", st_out_valid, 0);
        tick();
        bus_read(2'd1, rd);
        check("flush_status", rd, DROP ? 32'h0005_0000 : 32'h0001_0000);
        bus_write(2'd2, 32'h2, 4'h1);
        bus_read(2'd1, rd);
        check("clr_ovf_status", rd, 32'h0001_0000);

        // reset with queued words and a read issued in the same cycle
        for (int i = 0; i < 4; i++) bus_write(2'd0, 32'hD000_0000 + i, 4'hF);
        s_in_address = 4'd3;
        s_in_read = 1;
        rst_n = 0;
        tick();
        s_in_read = 0;
        rst_n = 1;
        @(negedge clk);
        check("rst_rdv_drop", s_in_readdatavalid, 0);
        check("rst_valid", st_out_valid, 0);
        tick();
        bus_read(2'd1, rd);
        check("rst_status", rd, 32'h0001_0000);
        bus_read(2'd3, rd);
        check("rst_count", rd, 0);

        // randomized traffic, model checks every cycle
        for (int c = 0; c < 2000; c++) begin
            int a;
            a = $urandom_range(0, 9);
            s_in_write = ($urandom_range(0, 99) < 45);
            s_in_read = ($urandom_range(0, 3) == 0);
            s_in_address = {2'($urandom_range(0, 3)),
                            (a < 6) ? 2'd0 : (a < 8) ? 2'd1 : (a == 8) ? 2'd3 : 2'd2};
            s_in_writedata = $urandom;
            if (s_in_address[1:0] == 2'd2 && $urandom_range(0, 7) != 0) s_in_writedata[0] = 1'b0;
            s_in_byteenable = 4'($urandom_range(0, 15));
            if (c < 700) st_out_ready = ($urandom_range(0, 3) == 0);
            else         st_out_ready = ($urandom_range(0, 2) != 0);
            rst_n = (c != 1300);
            tick();
        end
        rst_n = 1;
        s_in_write = 0;
        s_in_read = 0;
        st_out_ready = 1;
        repeat (DEPTH + 4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
